// File: rtl/tank1_hit_tracker_if.sv
// Bullet/tank geometry into the player-1 hit tracker and its status outputs back.
// master = game top level driving geometry; slave = tank1_hit_tracker.
interface tank1_hit_tracker_if;
  logic       bullet_on;
  logic [9:0] BulletX;
  logic [9:0] BulletY;
  logic [9:0] BulletS;
  logic [9:0] TankX;
  logic [9:0] TankY;
  logic [9:0] TankS;
  logic       hit_pulse;
  logic [2:0] lives;
  logic       invuln;
  logic       flash;
  logic       game_over;

  modport master (
    output bullet_on, BulletX, BulletY, BulletS, TankX, TankY, TankS,
    input  hit_pulse, lives, invuln, flash, game_over
  );

  modport slave (
    input  bullet_on, BulletX, BulletY, BulletS, TankX, TankY, TankS,
    output hit_pulse, lives, invuln, flash, game_over
  );
endinterface

// File: rtl/tank1_hit_tracker.sv
// Player-1 hit detection, lives and post-hit invulnerability, updated once per frame.
// Optional macro TANK1_HIT_FLASH_EN enables sprite flashing during invulnerability.
module tank1_hit_tracker #(
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int FLASH_PERIOD  = 4
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  tank1_hit_tracker_if.slave   bus
);

  localparam bit PARAMS_OK = (START_LIVES >= 1) && (START_LIVES <= 7) &&
                             (INVULN_FRAMES >= 1) && (INVULN_FRAMES <= 255) &&
                             (FLASH_PERIOD >= 1) && (FLASH_PERIOD <= 255);

  if (!PARAMS_OK) begin : g_bad_params
    $error("tank1_hit_tracker: parameter out of range");
  end

  localparam logic [2:0] LIVES_INIT = 3'(START_LIVES);
  localparam logic [7:0] INV_RELOAD = 8'(INVULN_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } state_t;

  state_t     state_q;
  logic [2:0] lives_q;
  logic [7:0] inv_cnt_q;
  logic       armed_q;
  logic       hit_pulse_q;
  logic       invuln_q;
  logic       game_over_q;

  logic [10:0] dx;
  logic [10:0] dy;
  logic [10:0] lim;
  logic        overlap;
  logic        hit_cond;

  // 11-bit differences and sum so wide boxes near the screen edge never wrap.
  always_comb begin
    dx = (bus.BulletX >= bus.TankX) ? ({1'b0, bus.BulletX} - {1'b0, bus.TankX})
                                    : ({1'b0, bus.TankX} - {1'b0, bus.BulletX});
    dy = (bus.BulletY >= bus.TankY) ? ({1'b0, bus.BulletY} - {1'b0, bus.TankY})
                                    : ({1'b0, bus.TankY} - {1'b0, bus.BulletY});
    lim      = {1'b0, bus.BulletS} + {1'b0, bus.TankS};
    overlap  = (dx <= lim) && (dy <= lim);
    hit_cond = bus.bullet_on && armed_q && overlap;
  end

`ifdef TANK1_HIT_FLASH_EN
  localparam logic [7:0] FLASH_RELOAD = 8'(FLASH_PERIOD - 1);
  logic       flash_q;
  logic [7:0] flash_cnt_q;
`endif

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q     <= ST_ALIVE;
      lives_q     <= LIVES_INIT;
      inv_cnt_q   <= 8'd0;
      armed_q     <= 1'b1;
      hit_pulse_q <= 1'b0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
`ifdef TANK1_HIT_FLASH_EN
      flash_q     <= 1'b0;
      flash_cnt_q <= 8'd0;
`endif
    end else begin
      hit_pulse_q <= 1'b0;

      // One hit per shot: disarm on contact, rearm only once the bullet is gone.
      if (hit_cond) begin
        armed_q <= 1'b0;
      end else if (!bus.bullet_on) begin
        armed_q <= 1'b1;
      end

      case (state_q)
        ST_ALIVE: begin
          if (hit_cond) begin
            hit_pulse_q <= 1'b1;
            if (lives_q > 3'd1) begin
              state_q   <= ST_INVULN;
              lives_q   <= lives_q - 3'd1;
              invuln_q  <= 1'b1;
              inv_cnt_q <= INV_RELOAD;
`ifdef TANK1_HIT_FLASH_EN
              flash_q     <= 1'b1;
              flash_cnt_q <= FLASH_RELOAD;
`endif
            end else begin
              state_q     <= ST_DEAD;
              lives_q     <= 3'd0;
              game_over_q <= 1'b1;
            end
          end
        end

        ST_INVULN: begin
          if (inv_cnt_q == 8'd0) begin
            state_q  <= ST_ALIVE;
            invuln_q <= 1'b0;
`ifdef TANK1_HIT_FLASH_EN
            flash_q  <= 1'b0;
`endif
          end else begin
            inv_cnt_q <= inv_cnt_q - 8'd1;
`ifdef TANK1_HIT_FLASH_EN
            if (flash_cnt_q == 8'd0) begin
              flash_q     <= ~flash_q;
              flash_cnt_q <= FLASH_RELOAD;
            end else begin
              flash_cnt_q <= flash_cnt_q - 8'd1;
            end
`endif
          end
        end

        ST_DEAD: begin
          lives_q     <= 3'd0;
          game_over_q <= 1'b1;
        end

        default: begin
          state_q <= ST_ALIVE;
        end
      endcase
    end
  end

  assign bus.hit_pulse = hit_pulse_q;
  assign bus.lives     = lives_q;
  assign bus.invuln    = invuln_q;
  assign bus.game_over = game_over_q;
`ifdef TANK1_HIT_FLASH_EN
  assign bus.flash     = flash_q;
`else
  assign bus.flash     = 1'b0;
`endif

endmodule

// File: tb/tb_tank1_hit_tracker.sv
// Directed and randomized checks of tank1_hit_tracker against a frame-level model.
module tb_tank1_hit_tracker;

  localparam int START_LIVES   = 3;
  localparam int INVULN_FRAMES = 60;
  localparam int FLASH_PERIOD  = 4;

  logic frame_clk = 1'b0;
  logic Reset;
  int   errors = 0;
  int   checks = 0;

  // Model state: lives, frames of invulnerability still to run, armed, dead.
  int m_lives;
  int m_inv_left;
  int m_armed;
  int m_dead;
  int m_pulse;
  int prev_pulse;
  int pulse_cnt;

  tank1_hit_tracker_if dut_if ();

  tank1_hit_tracker #(
    .START_LIVES  (START_LIVES),
    .INVULN_FRAMES(INVULN_FRAMES),
    .FLASH_PERIOD (FLASH_PERIOD)
  ) dut (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .bus      (dut_if)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int exp_flash();
    int age;
`ifdef TANK1_HIT_FLASH_EN
    if (m_inv_left == 0) return 0;
    age = INVULN_FRAMES - m_inv_left;
    return ((age / FLASH_PERIOD) % 2 == 0) ? 1 : 0;
`else
    age = 0;
    return age;
`endif
  endfunction

  // One frame: drive inputs, advance the model at the edge, compare all outputs.
  task automatic step(input int rst, input int bon, input int bx, input int by,
                      input int bs, input int tx, input int ty, input int ts);
    int lim;
    int ov;
    int hc;
    Reset            = rst[0];
    dut_if.bullet_on = bon[0];
    dut_if.BulletX   = 10'(bx);
    dut_if.BulletY   = 10'(by);
    dut_if.BulletS   = 10'(bs);
    dut_if.TankX     = 10'(tx);
    dut_if.TankY     = 10'(ty);
    dut_if.TankS     = 10'(ts);
    @(posedge frame_clk);
    lim = bs + ts;
    ov  = (iabs(bx - tx) <= lim) && (iabs(by - ty) <= lim);
    hc  = bon && m_armed && ov;
    m_pulse = 0;
    if (rst != 0) begin
      m_lives = START_LIVES; m_inv_left = 0; m_armed = 1; m_dead = 0;
    end else begin
      if (m_dead != 0) begin
        m_lives = 0;
      end else if (m_inv_left > 0) begin
        m_inv_left--;
      end else if (hc != 0) begin
        m_pulse = 1;
        m_lives--;
        if (m_lives == 0) m_dead = 1;
        else m_inv_left = INVULN_FRAMES;
      end
      if (hc != 0) m_armed = 0;
      else if (bon == 0) m_armed = 1;
    end
    #1;
    check("hit_pulse", int'(dut_if.hit_pulse), m_pulse);
    check("lives",     int'(dut_if.lives),     m_lives);
    check("invuln",    int'(dut_if.invuln),    (m_inv_left > 0) ? 1 : 0);
    check("flash",     int'(dut_if.flash),     exp_flash());
    check("game_over", int'(dut_if.game_over), m_dead);
    check("no_double_pulse", prev_pulse & int'(dut_if.hit_pulse), 0);
    prev_pulse = int'(dut_if.hit_pulse);
    if (dut_if.hit_pulse === 1'b1) pulse_cnt++;
  endtask

  initial begin
    int bx, by, bs, tx, ty, ts, bon, rst;
    m_lives = 0; m_inv_left = 0; m_armed = 1; m_dead = 0; m_pulse = 0;
    prev_pulse = 0; pulse_cnt = 0;

    // Reset state.
    step(1, 0, 0, 0, 0, 100, 100, 8);
    step(1, 0, 0, 0, 0, 100, 100, 8);
    check("reset_lives", int'(dut_if.lives), 3);

    // dx = 13 > 12 and dy = 13 > 12: no hit.
    for (int i = 0; i < 3; i++) step(0, 1, 113, 100, 4, 100, 100, 8);
    for (int i = 0; i < 3; i++) step(0, 1, 100, 87, 4, 100, 100, 8);
    check("miss_lives", int'(dut_if.lives), 3);

    // Touching edge hit, bullet lingers for 100 frames: exactly one pulse.
    pulse_cnt = 0;
    step(0, 1, 112, 100, 4, 100, 100, 8);
    check("edge_hit_pulse", int'(dut_if.hit_pulse), 1);
    check("edge_hit_lives", int'(dut_if.lives), 2);
    for (int i = 1; i < 100; i++) step(0, 1, 112, 100, 4, 100, 100, 8);
    check("linger_one_pulse", pulse_cnt, 1);
    check("linger_alive", int'(dut_if.invuln), 0);

    // Rearm, second hit (dy boundary), wait out invulnerability, fatal third hit.
    step(0, 0, 100, 112, 4, 100, 100, 8);
    step(0, 1, 100, 112, 4, 100, 100, 8);
    check("second_hit_lives", int'(dut_if.lives), 1);
    for (int i = 0; i < 61; i++) step(0, 0, 100, 100, 4, 100, 100, 8);
    step(0, 1, 95, 104, 4, 100, 100, 8);
    check("third_hit_go", int'(dut_if.hit_pulse & dut_if.game_over), 1);
    for (int i = 0; i < 10; i++) step(0, i % 2, 100, 100, 4, 100, 100, 8);
    check("dead_lives", int'(dut_if.lives), 0);

    // Reset 20 frames into invulnerability, then an immediate hit proves armed=1.
    step(1, 0, 0, 0, 0, 100, 100, 8);
    step(0, 1, 112, 100, 4, 100, 100, 8);
    for (int i = 0; i < 20; i++) step(0, 1, 112, 100, 4, 100, 100, 8);
    step(1, 1, 112, 100, 4, 100, 100, 8);
    check("midinv_reset_invuln", int'(dut_if.invuln), 0);
    check("midinv_reset_lives", int'(dut_if.lives), 3);
    step(0, 1, 112, 100, 4, 100, 100, 8);
    check("rearmed_hit", int'(dut_if.hit_pulse), 1);

    // Randomized frames: mostly near the tank, some wide boxes to exercise 11-bit sums.
    step(1, 0, 0, 0, 0, 100, 100, 8);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0) ? 1 : 0;
      bon = ($urandom_range(0, 3) != 0) ? 1 : 0;
      if ($urandom_range(0, 9) == 0) begin
        tx = $urandom_range(0, 1023); ty = $urandom_range(0, 1023);
        bx = $urandom_range(0, 1023); by = $urandom_range(0, 1023);
        ts = $urandom_range(0, 1023); bs = $urandom_range(0, 1023);
      end else begin
        tx = $urandom_range(200, 210); ty = $urandom_range(200, 210);
        bx = tx + $urandom_range(0, 40) - 20; by = ty + $urandom_range(0, 40) - 20;
        ts = $urandom_range(0, 8); bs = $urandom_range(0, 6);
      end
      step(rst, bon, bx, by, bs, tx, ty, ts);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
